// File: rtl/i2c_axi_slave_mc.sv
// i2c_axi_slave_mc: AXI4-Lite register slave for C_NUM_CH I2C engines.
// Per channel: CMD FIFO, STATUS, IRQ_PEND (W1C), IRQ_EN, LEVEL.
// Ports: S_AXI_* AXI4-Lite slave (PROT/WSTRB ignored);
//   i2c_cmd_valid_o/data_o/ready_i: per-channel FIFO head handshake;
//   i2c_status_reg_i, i2c_done_i: engine status and done pulses;
//   irq_o: registered OR of pend & en over all channels.

module i2c_axi_slave_mc #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 13,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 13'h1000,
   parameter int C_NUM_CH = 2,
   parameter int C_CMD_FIFO_DEPTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_NUM_CH-1:0]             i2c_cmd_valid_o,
   output logic [11*C_NUM_CH-1:0]          i2c_cmd_data_o,
   input  logic [C_NUM_CH-1:0]             i2c_cmd_ready_i,
   input  logic [10*C_NUM_CH-1:0]          i2c_status_reg_i,
   input  logic [C_NUM_CH-1:0]             i2c_done_i,
   output logic                            irq_o
);

   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int CW = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;
   localparam int PW = $clog2(C_CMD_FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(C_CMD_FIFO_DEPTH);

   logic                aw_held, w_held;
   logic [AW-1:0]       awaddr_q;
   logic [10:0]         wdata_q;
   logic [10:0]         mem [C_NUM_CH][C_CMD_FIFO_DEPTH];
   logic [PW-1:0]       wptr [C_NUM_CH];
   logic [PW-1:0]       rptr [C_NUM_CH];
   logic [LW-1:0]       cnt [C_NUM_CH];
   logic [9:0]          status_a [C_NUM_CH];
   logic [C_NUM_CH-1:0] pend, en, full, push, pop, clr, en_wr;
   logic                wr_do, wr_map, wr_err, rd_map;
   logic [CW-1:0]       wr_ch, rd_ch;
   logic [4:0]          wr_off, rd_off;
   logic [31:0]         rd_data;
   logic                unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                        S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:11]};

   // Mapped = inside a channel window, word aligned, offset <= 0x10.
   function automatic void dec(input  logic [AW-1:0] a,
                               output logic          map,
                               output logic [CW-1:0] ch,
                               output logic [4:0]    off);
      logic [AW-1:0] rel;
      rel = a - C_BASE_ADDR;
      map = (a >= C_BASE_ADDR) &&
            ((rel >> 5) < AW'(C_NUM_CH)) &&
            (rel[1:0] == 2'b00) &&
            (rel[4:0] <= 5'h10);
      ch  = rel[5 +: CW];
      off = rel[4:0];
   endfunction

   for (genvar n = 0; n < C_NUM_CH; n++) begin : g_ch
      assign full[n] = (cnt[n] == FULL);
      assign i2c_cmd_valid_o[n] = (cnt[n] != '0);
      assign i2c_cmd_data_o[11*n +: 11] = mem[n][rptr[n]];
      assign pop[n] = i2c_cmd_valid_o[n] && i2c_cmd_ready_i[n];
      assign status_a[n] = i2c_status_reg_i[10*n +: 10];
   end

   always_comb begin
      dec(awaddr_q, wr_map, wr_ch, wr_off);
      dec(S_AXI_ARADDR, rd_map, rd_ch, rd_off);
      wr_do  = aw_held && w_held && !S_AXI_BVALID;
      // Fullness is judged before any pop in the same cycle.
      wr_err = !wr_map || ((wr_off == 5'h00) && full[wr_ch]);
      push   = '0;
      clr    = '0;
      en_wr  = '0;
      for (int n = 0; n < C_NUM_CH; n++) begin
         if (wr_do && wr_map && (wr_ch == CW'(n))) begin
            push[n]  = (wr_off == 5'h00) && !full[n];
            clr[n]   = (wr_off == 5'h08) && wdata_q[0];
            en_wr[n] = (wr_off == 5'h0C);
         end
      end
      rd_data = '0;
      if (rd_map) begin
         unique case (1'b1)
            rd_off == 5'h00:
               rd_data = (cnt[rd_ch] != '0) ?
                         32'(mem[rd_ch][rptr[rd_ch]]) : '0;
            rd_off == 5'h04: rd_data = 32'(status_a[rd_ch]);
            rd_off == 5'h08: rd_data = 32'(pend[rd_ch]);
            rd_off == 5'h0C: rd_data = 32'(en[rd_ch]);
            default:         rd_data = 32'(cnt[rd_ch]);
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= 2'b00;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= 2'b00;
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         pend          <= '0;
         en            <= '0;
         irq_o         <= 1'b0;
         for (int n = 0; n < C_NUM_CH; n++) begin
            wptr[n] <= '0;
            rptr[n] <= '0;
            cnt[n]  <= '0;
            for (int d = 0; d < C_CMD_FIFO_DEPTH; d++)
               mem[n][d] <= '0;
         end
      end else begin
         if (S_AXI_AWREADY) begin
            S_AXI_AWREADY <= 1'b0;
            if (S_AXI_AWVALID) begin
               aw_held  <= 1'b1;
               awaddr_q <= S_AXI_AWADDR;
            end
         end else if (S_AXI_AWVALID && !aw_held && !S_AXI_BVALID) begin
            S_AXI_AWREADY <= 1'b1;
         end
         if (S_AXI_WREADY) begin
            S_AXI_WREADY <= 1'b0;
            if (S_AXI_WVALID) begin
               w_held  <= 1'b1;
               wdata_q <= S_AXI_WDATA[10:0];
            end
         end else if (S_AXI_WVALID && !w_held && !S_AXI_BVALID) begin
            S_AXI_WREADY <= 1'b1;
         end
         if (wr_do) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_err ? 2'b10 : 2'b00;
         end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
         if (S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_data;
            S_AXI_RRESP   <= rd_map ? 2'b00 : 2'b10;
         end else if (S_AXI_ARVALID && !S_AXI_RVALID) begin
            S_AXI_ARREADY <= 1'b1;
         end
         if (S_AXI_RVALID && S_AXI_RREADY)
            S_AXI_RVALID <= 1'b0;
         for (int n = 0; n < C_NUM_CH; n++) begin
            if (push[n]) begin
               mem[n][wptr[n]] <= wdata_q;
               wptr[n] <= wptr[n] + PW'(1);
            end
            if (pop[n])
               rptr[n] <= rptr[n] + PW'(1);
            cnt[n] <= cnt[n] + LW'(push[n]) - LW'(pop[n]);
            // A done pulse beats a simultaneous W1C.
            if (i2c_done_i[n])
               pend[n] <= 1'b1;
            else if (clr[n])
               pend[n] <= 1'b0;
            if (en_wr[n])
               en[n] <= wdata_q[0];
         end
         irq_o <= |(pend & en);
      end
   end

endmodule

// File: tb/tb_i2c_axi_slave_mc.sv
// tb_i2c_axi_slave_mc: directed + random bench for i2c_axi_slave_mc.
// Register-level reference model built from queues and flag arrays.

module tb_i2c_axi_slave_mc;

   localparam int NCH = 2;
   localparam int DEP = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [12:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, arvalid, arready, rvalid, rready;
   logic [NCH-1:0]    cmd_valid, cmd_ready, done;
   logic [11*NCH-1:0] cmd_data;
   logic [10*NCH-1:0] status;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   logic [10:0] q [NCH][$];
   bit          m_pend [NCH];
   bit          m_en [NCH];

   always #5 clk = ~clk;

   i2c_axi_slave_mc #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(13),
      .C_BASE_ADDR(13'h1000),
      .C_NUM_CH(NCH),
      .C_CMD_FIFO_DEPTH(DEP)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr),
      .S_AXI_AWPROT(awprot),
      .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata),
      .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid),
      .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp),
      .S_AXI_BVALID(bvalid),
      .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr),
      .S_AXI_ARPROT(arprot),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata),
      .S_AXI_RRESP(rresp),
      .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready),
      .i2c_cmd_valid_o(cmd_valid),
      .i2c_cmd_data_o(cmd_data),
      .i2c_cmd_ready_i(cmd_ready),
      .i2c_status_reg_i(status),
      .i2c_done_i(done),
      .irq_o(irq)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_clk();
      @(posedge clk);
      #1;
   endtask

   function automatic void mdec(input logic [12:0] a, output bit m,
                                output int ch, output int off);
      int rel;
      rel = int'(a) - 32'h1000;
      m = (rel >= 0) && (rel / 32 < NCH) &&
          (rel % 4 == 0) && (rel % 32 <= 16);
      ch  = m ? rel / 32 : 0;
      off = m ? rel % 32 : 0;
   endfunction

   function automatic logic [33:0] m_read(input logic [12:0] a);
      bit m;
      int ch, off;
      logic [31:0] d;
      mdec(a, m, ch, off);
      if (!m) return {2'b10, 32'h0};
      case (off)
         0:  d = (q[ch].size() > 0) ? 32'(q[ch][0]) : 32'h0;
         4:  d = 32'(status[ch*10 +: 10]);
         8:  d = 32'(m_pend[ch]);
         12: d = 32'(m_en[ch]);
         default: d = 32'(q[ch].size());
      endcase
      return {2'b00, d};
   endfunction

   function automatic logic [1:0] m_write(input logic [12:0] a,
                                          input logic [31:0] d);
      bit m;
      int ch, off;
      mdec(a, m, ch, off);
      if (!m) return 2'b10;
      case (off)
         0: begin
            if (q[ch].size() == DEP) return 2'b10;
            q[ch].push_back(d[10:0]);
         end
         8:  if (d[0]) m_pend[ch] = 1'b0;
         12: m_en[ch] = d[0];
         default: ;
      endcase
      return 2'b00;
   endfunction

   task automatic axi_wr(input logic [12:0] a, input logic [31:0] d,
                         input int awd, input int wd, input bit bhold,
                         output logic [1:0] resp);
      bit awok = 0, wok = 0, ahs, whs;
      int c = 0;
      awaddr = a;
      wdata  = d;
      wstrb  = 4'($urandom);
      awprot = 3'($urandom);
      while (!(awok && wok) && c < 40) begin
         if (!awok && c >= awd) awvalid = 1'b1;
         if (!wok && c >= wd) wvalid = 1'b1;
         ahs = awvalid && awready;
         whs = wvalid && wready;
         wait_clk();
         if (ahs) begin awvalid = 1'b0; awok = 1; end
         if (whs) begin wvalid = 1'b0; wok = 1; end
         c++;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      chk("wr_handshake", {30'h0, awok, wok}, 32'h3);
      c = 0;
      while (!bvalid && c < 20) begin
         wait_clk();
         c++;
      end
      chk("bvalid", 32'(bvalid), 32'h1);
      resp = bresp;
      if (!bhold) begin
         bready = 1'b1;
         wait_clk();
         bready = 1'b0;
         chk("bvalid_clear", 32'(bvalid), 32'h0);
      end
   endtask

   task automatic do_wr(input logic [12:0] a, input logic [31:0] d,
                        input int awd, input int wd);
      logic [1:0] r, e;
      axi_wr(a, d, awd, wd, 1'b0, r);
      e = m_write(a, d);
      chk("bresp", 32'(r), 32'(e));
   endtask

   // AW and W together; done/ready driven only for the effect cycle.
   task automatic do_sync(input logic [12:0] a, input logic [31:0] d,
                          input logic [NCH-1:0] dm,
                          input logic [NCH-1:0] rm);
      logic [1:0] e;
      int pre [NCH];
      int c = 0;
      awaddr  = a;
      wdata   = d;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      while (!(awready && wready) && c < 20) begin
         wait_clk();
         c++;
      end
      chk("sync_ready", {30'h0, awready, wready}, 32'h3);
      wait_clk();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      done = dm;
      cmd_ready = rm;
      for (int n = 0; n < NCH; n++) pre[n] = q[n].size();
      e = m_write(a, d);
      for (int n = 0; n < NCH; n++) begin
         if (rm[n] && pre[n] > 0) void'(q[n].pop_front());
         if (dm[n]) m_pend[n] = 1'b1;
      end
      wait_clk();
      done = '0;
      cmd_ready = '0;
      chk("sync_bvalid", 32'(bvalid), 32'h1);
      chk("sync_bresp", 32'(bresp), 32'(e));
      bready = 1'b1;
      wait_clk();
      bready = 1'b0;
   endtask

   task automatic do_rd(input logic [12:0] a, input int hold);
      logic [33:0] e;
      bit ok = 0, hs;
      int c = 0;
      e = m_read(a);
      araddr  = a;
      arprot  = 3'($urandom);
      arvalid = 1'b1;
      while (!ok && c < 20) begin
         hs = arvalid && arready;
         wait_clk();
         if (hs) ok = 1;
         c++;
      end
      chk("rd_handshake", 32'(ok), 32'h1);
      if (hold == 0) arvalid = 1'b0;
      repeat (hold) begin
         wait_clk();
         chk("hold_rvalid", 32'(rvalid), 32'h1);
         chk("hold_rdata", rdata, e[31:0]);
         chk("hold_arready", 32'(arready), 32'h0);
      end
      chk("rvalid", 32'(rvalid), 32'h1);
      chk("rdata", rdata, e[31:0]);
      chk("rresp", 32'(rresp), 32'(e[33:32]));
      arvalid = 1'b0;
      rready  = 1'b1;
      wait_clk();
      rready  = 1'b0;
      chk("rvalid_clear", 32'(rvalid), 32'h0);
   endtask

   task automatic pop(input int n);
      chk("pop_valid", 32'(cmd_valid[n]), 32'(q[n].size() > 0));
      if (q[n].size() > 0)
         chk("pop_data", 32'(cmd_data[11*n +: 11]), 32'(q[n][0]));
      cmd_ready[n] = 1'b1;
      wait_clk();
      cmd_ready[n] = 1'b0;
      if (q[n].size() > 0) void'(q[n].pop_front());
   endtask

   task automatic pulse_done(input int n);
      done[n] = 1'b1;
      wait_clk();
      done[n] = 1'b0;
      m_pend[n] = 1'b1;
   endtask

   task automatic check_outs();
      bit e = 0;
      wait_clk();
      for (int n = 0; n < NCH; n++) begin
         chk("cmd_valid", 32'(cmd_valid[n]), 32'(q[n].size() > 0));
         if (q[n].size() > 0)
            chk("cmd_data", 32'(cmd_data[11*n +: 11]), 32'(q[n][0]));
         e = e | (m_pend[n] & m_en[n]);
      end
      chk("irq", 32'(irq), 32'(e));
   endtask

   task automatic reset_chk();
      chk("rst_awready", 32'(awready), 32'h0);
      chk("rst_wready", 32'(wready), 32'h0);
      chk("rst_bvalid", 32'(bvalid), 32'h0);
      chk("rst_bresp", 32'(bresp), 32'h0);
      chk("rst_arready", 32'(arready), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_rresp", 32'(rresp), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'h0);
      chk("rst_cmd_data", 32'(cmd_data), 32'h0);
   endtask

   function automatic logic [12:0] pick_addr(input int ch);
      int r, b;
      r = $urandom_range(0, 9);
      b = 32'h1000 + ch * 32;
      case (r)
         0, 1, 2, 3, 4: return 13'(b + 4 * r);
         5: return 13'(b + 20);
         6: return 13'(b + 2);
         7: return 13'h1040;
         8: return 13'h0FFC;
         default: return 13'h1FFC;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      logic [1:0] r;
      int op, ch;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      wdata = '0; wstrb = '0; cmd_ready = '0; done = '0;
      status = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_chk();
      @(negedge clk) rst_n = 1'b1;
      wait_clk();

      // Push order with W trailing AW, then one pop.
      do_wr(13'h1000, 32'h155, 0, 3);
      do_wr(13'h1000, 32'h0AA, 2, 0);
      check_outs();
      do_rd(13'h1010, 0);
      pop(0);
      check_outs();
      do_rd(13'h1010, 0);
      do_rd(13'h1000, 0);
      do_wr(13'h1004, 32'h3FF, 3, 0);

      // Fill ch1, overflow, then push at full with a pop.
      for (int i = 0; i < 5; i++)
         do_wr(13'h1020, 32'($urandom), 0, i % 3);
      do_rd(13'h1030, 0);
      do_sync(13'h1020, 32'h7FF, 2'b00, 2'b10);
      do_rd(13'h1030, 0);
      while (q[1].size() > 0) pop(1);
      check_outs();

      // Status readback with a long RREADY stall.
      status[19:10] = 10'h2A5;
      do_rd(13'h1024, 5);

      // IRQ enable, set, set-vs-clear race, clear.
      do_wr(13'h100C, 32'h1, 0, 0);
      pulse_done(0);
      check_outs();
      do_rd(13'h1008, 0);
      do_sync(13'h1008, 32'h1, 2'b01, 2'b00);
      check_outs();
      do_rd(13'h1008, 0);
      do_wr(13'h1008, 32'h1, 1, 0);
      check_outs();

      // Unmapped accesses.
      do_rd(13'h1014, 0);
      do_rd(13'h1002, 0);
      do_rd(13'h1040, 0);
      do_wr(13'h0FFF, 32'h1, 0, 0);
      do_rd(13'h100C, 0);
      do_rd(13'h1010, 0);

      repeat (300) begin
         status = 20'($urandom);
         op = $urandom_range(0, 7);
         ch = $urandom_range(0, NCH - 1);
         case (op)
            0, 1: do_wr(13'(32'h1000 + ch * 32), 32'($urandom),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            2: do_rd(pick_addr(ch), $urandom_range(0, 2));
            3: pop(ch);
            4: pulse_done(ch);
            5: do_wr(13'(32'h1008 + ch * 32 + 4 * $urandom_range(0, 1)),
                     32'($urandom), 0, $urandom_range(0, 2));
            6: do_sync(pick_addr(ch), 32'($urandom),
                       NCH'($urandom), NCH'($urandom));
            default: do_wr(pick_addr(ch), 32'($urandom),
                           $urandom_range(0, 2), 0);
         endcase
         check_outs();
      end

      // Asynchronous reset with a response pending.
      while (q[0].size() > 0) pop(0);
      do_wr(13'h1000, 32'h011, 0, 0);
      do_wr(13'h1000, 32'h022, 0, 0);
      do_wr(13'h100C, 32'h1, 0, 0);
      pulse_done(0);
      check_outs();
      axi_wr(13'h1004, 32'h0, 0, 0, 1'b1, r);
      chk("pre_rst_bresp", 32'(r), 32'h0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_bvalid", 32'(bvalid), 32'h0);
      chk("arst_cmd_valid", 32'(cmd_valid), 32'h0);
      chk("arst_irq", 32'(irq), 32'h0);
      chk("arst_cmd_data", 32'(cmd_data), 32'h0);
      for (int n = 0; n < NCH; n++) begin
         q[n].delete();
         m_pend[n] = 1'b0;
         m_en[n] = 1'b0;
      end
      @(negedge clk) rst_n = 1'b1;
      check_outs();
      do_rd(13'h1010, 0);
      do_rd(13'h1030, 0);
      do_rd(13'h100C, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_axi_slave_mc.md
Name: i2c_axi_slave_mc

Overview:
Parametrised multi-channel AXI4-Lite register slave for the I2C controller subsystem. It serves C_NUM_CH I2C engines, each with its own command FIFO, live status readback, sticky done-interrupt with enable, and FIFO level readback. AW and W channels are accepted independently. Unmapped accesses and command pushes to a full FIFO return SLVERR. It sits between the AXI interconnect and the per-channel I2C engines, and drives one combined interrupt line.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 13, AXI address width.
C_BASE_ADDR, 13'h1000, byte address of channel 0's register window.
C_NUM_CH, 2, number of I2C channels (1..8); each channel occupies a 0x20-byte window at C_BASE_ADDR + ch*0x20.
C_CMD_FIFO_DEPTH, 4, entries per command FIFO; power of two, 2..16.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite widths; PROT is ignored.
i2c_cmd_valid_o  out  C_NUM_CH  per-channel FIFO not empty
i2c_cmd_data_o  out  11*C_NUM_CH  FIFO head; channel n occupies bits [11n+10:11n]
i2c_cmd_ready_i  in  C_NUM_CH  engine pops the head when valid&ready
i2c_status_reg_i  in  10*C_NUM_CH  live engine status, read-only
i2c_done_i  in  C_NUM_CH  single-cycle completion pulse per channel
irq_o  out  1  registered OR over all channels of (pend & en)

Behaviour:
- Reset: all outputs are 0, including all READY/VALID signals, BRESP, RRESP, RDATA and irq_o. FIFOs are empty. All pend and en bits are 0.
- Per-channel offsets:
  - 0x00 CMD: write pushes WDATA[10:0]. Reads return the head, or 0 if the FIFO is empty.
  - 0x04 STATUS: read-only, zero-extended 10-bit status.
  - 0x08 IRQ_PEND: bit0 is write-1-to-clear.
  - 0x0C IRQ_EN: bit0 is read/write.
  - 0x10 LEVEL: read-only, FIFO occupancy, width $clog2(depth)+1.
- Mapped address: in range, word-aligned, offset <= 0x10, channel < C_NUM_CH. Anything else is unmapped.
- Write channel:
  - AWREADY pulses for 1 cycle when AWVALID is high and no address is held; AWADDR is latched.
  - WREADY pulses independently in the same way; WDATA is latched.
  - Either may be accepted before the other.
  - When both are held and BVALID=0: perform the register effect, set BVALID and BRESP the next cycle, and release both holds.
  - No new AW/W is accepted while BVALID=1. BVALID clears on BREADY.
  - WSTRB is ignored.
- Write responses:
  - BRESP=2'b00 (OKAY) for a mapped write.
  - BRESP=2'b10 (SLVERR) for an unmapped write, with no side effect.
  - BRESP=2'b10 for a CMD push when the FIFO is full before this cycle's pop. The data is dropped.
  - Writes to STATUS and LEVEL return OKAY and are ignored.
- Read channel:
  - ARREADY pulses for 1 cycle when ARVALID is high and RVALID=0.
  - The next cycle, RVALID=1 and RDATA/RRESP are registered from the latched address.
  - Unmapped reads return RDATA=0 with RRESP=2'b10.
  - RDATA and RRESP are held stable until RREADY. No new AR is accepted while RVALID=1.
  - Reads have no side effects, including reads of CMD.
- FIFO:
  - Circular buffer; pointers wrap modulo depth.
  - Push and pop in the same cycle are both honoured when not full; the level is unchanged.
  - Pop when empty is impossible because valid=0.
  - i2c_cmd_valid_o and i2c_cmd_data_o come directly from storage and the pointers (no extra latency). A push is visible at the head the cycle after the write's effect.
- IRQ:
  - pend[n] sets on i2c_done_i[n].
  - A W1C clear in the same cycle as a set: the set wins and pend stays 1.
  - irq_o updates 1 cycle after pend or en changes.
- Reset asserted mid-transaction: everything returns immediately to reset values. The in-flight transaction is abandoned.

Test Plan:
1. Push order: AW then W 3 cycles later, writing 0x155 to 0x1000; then write 0x0AA. Expect BRESP=00 for both, i2c_cmd_valid_o[0]=1, data[10:0]=0x155; LEVEL (0x1010) reads 2. Pulse ready 1 cycle: head=0x0AA, LEVEL=1.
2. Full FIFO: depth 4, ready=0, five pushes to 0x1020 (ch1). Expect pushes 1-4 OKAY and the 5th SLVERR; LEVEL=4; pop order matches push order with the 5th value absent. Then, at full, push while ready=1: expect SLVERR, LEVEL=3.
3. Status readback: i2c_status_reg_i ch1 = 10'h2A5, read 0x1024. Expect RDATA=0x000002A5, RRESP=00. Hold RREADY=0 for 5 cycles: RDATA and RVALID are stable and ARREADY stays low.
4. IRQ: write 1 to IRQ_EN 0x100C, then pulse done[0]. Expect pend=1 and irq_o=1 one cycle later. Write 1 to 0x1008 in the same cycle as another done[0] pulse: pend stays 1. A later clear with no pulse: irq_o=0.
5. Unmapped: read 0x1014, 0x1002 (misaligned), and 0x1040 with C_NUM_CH=2. Expect RDATA=0 and RRESP=10 for each. Write 0x0FFF: BRESP=10 and no register changes.
6. Reset mid-transaction: assert ARESETN=0 asynchronously with BVALID=1 and two FIFO entries queued. Expect BVALID=0, i2c_cmd_valid_o=0, irq_o=0 and LEVEL=0 immediately, without waiting for a clock edge.
